// File: rtl/piso_shift.sv
// ---------------------------------------------------------------------------
// piso_shift -- parallel-in serial-out shifter with bit/frame/done markers.
//
// Takes a WIDTH-bit word over a valid/ready handshake and sends it one bit
// at a time on sdo. Each bit is held for CLKDIV clocks. bit_stb marks the
// first clock of every bit, frame marks the whole of bit 0, and done pulses
// once a word's last bit period has ended. Back-to-back words stream with no
// idle gap: the word is reloaded on the last clock of the last bit.
//
// Parameters:
//   WIDTH     word length in bits (>= 2)
//   CLKDIV    clocks per serial bit (>= 1)
//   MSB_FIRST 1: bit WIDTH-1 goes first, 0: bit 0 goes first
//   IDLE      level on sdo while no word is being shifted
//
// Ports:
//   ck        system clock, rising edge
//   rst       asynchronous active-high reset
//   in_data   word to serialise, sampled on accept
//   in_valid  in_data is valid
//   in_ready  block can accept a word this cycle (combinational from state)
//   sdo       serial data out (registered)
//   bit_stb   first clock of every bit period (registered)
//   frame     whole first bit period of each word (registered)
//   busy      a word is being shifted (registered)
//   done      one-clock pulse after a word's last bit period (registered)
// ---------------------------------------------------------------------------
module piso_shift #(
  parameter int   WIDTH     = 16,
  parameter int   CLKDIV    = 1,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE      = 1'b0
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sdo,
  output logic             bit_stb,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int BCW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int DCW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(CLKDIV - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [BCW-1:0]   bit_cnt;
  logic [DCW-1:0]   div_cnt;

  logic             bit_end;
  logic             last_clk;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_adv;

  // NOTE: continuous assigns for all combinational terms -- every signal has
  // exactly one unconditional driver, so no latch can be inferred.
  assign bit_end  = (div_cnt == DIV_LAST);
  assign last_clk = (state == ST_SHIFT) && bit_end && (bit_cnt == BIT_LAST);

  // Ready only depends on state and counters, never on in_valid.
  assign in_ready = (state == ST_IDLE) || last_clk;
  assign accept   = in_ready && in_valid;

  // sdo always shows the bit at the "front" of shreg; the register is shifted
  // towards the front on every bit boundary, so the next bit sits one place in.
  assign first_bit = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
  assign next_bit  = MSB_FIRST ? shreg[WIDTH-2]   : shreg[1];
  assign shreg_adv = MSB_FIRST ? (shreg << 1)     : (shreg >> 1);

  // NOTE: non-blocking assignments only in the clocked block, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      // NOTE: the shift register is reset along with the control state; it is
      // a handful of flops, not a memory array, so the reset costs nothing.
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      sdo     <= IDLE;
      bit_stb <= 1'b0;
      frame   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      bit_stb <= 1'b0;
      done    <= 1'b0;
      if (accept) begin
        // Fresh load from idle, or seamless reload on the last clock of a word;
        // in the reload case the finishing word's done lands on this same edge.
        state   <= ST_SHIFT;
        shreg   <= in_data;
        bit_cnt <= '0;
        div_cnt <= '0;
        sdo     <= first_bit;
        bit_stb <= 1'b1;
        frame   <= 1'b1;
        busy    <= 1'b1;
        done    <= (state == ST_SHIFT);
      end else if (state == ST_SHIFT) begin
        if (bit_end) begin
          div_cnt <= '0;
          if (bit_cnt == BIT_LAST) begin
            state <= ST_IDLE;
            sdo   <= IDLE;
            frame <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= shreg_adv;
            sdo     <= next_bit;
            bit_stb <= 1'b1;
            frame   <= 1'b0;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_shift.sv
// ---------------------------------------------------------------------------
// tb_piso_shift -- directed bench for piso_shift.
//
// Three instances cover the parameter sets needed (shared inputs):
//   [0] WIDTH=8 CLKDIV=1 MSB_FIRST=1 IDLE=0
//   [1] WIDTH=8 CLKDIV=3 MSB_FIRST=1 IDLE=0
//   [2] WIDTH=8 CLKDIV=1 MSB_FIRST=0 IDLE=1
// The stimulus pushes each word's hand-written serial pattern into a queue;
// a monitor on the falling edge pops one entry per bit_stb of the selected
// instance and compares sdo/frame. Cycle-exact markers are checked inline.
// ---------------------------------------------------------------------------
module tb_piso_shift;

  typedef struct packed {
    logic sdo;
    logic frame;
  } bit_t;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;

  logic [2:0] rdy, sdo, stb, frm, bsy, dn;

  localparam logic [2:0] IDLE_LVL = 3'b100;

  int   sel = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit_t exp_q[$];
  bit_t mon_e;

  always #5 ck = ~ck;

  piso_shift #(.WIDTH(8), .CLKDIV(1), .MSB_FIRST(1'b1), .IDLE(1'b0)) u_a (
    .ck(ck), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .sdo(sdo[0]), .bit_stb(stb[0]), .frame(frm[0]),
    .busy(bsy[0]), .done(dn[0]));

  piso_shift #(.WIDTH(8), .CLKDIV(3), .MSB_FIRST(1'b1), .IDLE(1'b0)) u_b (
    .ck(ck), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .sdo(sdo[1]), .bit_stb(stb[1]), .frame(frm[1]),
    .busy(bsy[1]), .done(dn[1]));

  piso_shift #(.WIDTH(8), .CLKDIV(1), .MSB_FIRST(1'b0), .IDLE(1'b1)) u_c (
    .ck(ck), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[2]), .sdo(sdo[2]), .bit_stb(stb[2]), .frame(frm[2]),
    .busy(bsy[2]), .done(dn[2]));

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // seq holds the bits in send order, first-sent bit in seq[7].
  task automatic push_word(input logic [7:0] seq, input int nbits);
    bit_t e;
    for (int i = 0; i < nbits; i++) begin
      e.sdo   = seq[7-i];
      e.frame = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: one expected bit per strobe of the selected instance.
  always @(negedge ck) begin
    if (stb[sel]) begin
      check("bit_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("sdo_bit", sdo[sel], mon_e.sdo);
        check("frame_bit", frm[sel], mon_e.frame);
      end
    end else if (!bsy[sel]) begin
      check("idle_sdo", sdo[sel], IDLE_LVL[sel]);
    end
  end

  initial begin
    logic [7:0] pat;

    // Reset values
    idle(2);
    check("rst_ready", rdy[0], 1);
    check("rst_sdo",   sdo[0], 0);
    check("rst_stb",   stb[0], 0);
    check("rst_frame", frm[0], 0);
    check("rst_busy",  bsy[0], 0);
    check("rst_done",  dn[0],  0);
    check("rst_sdo_idle1", sdo[2], 1);
    rst = 1'b0;
    idle(2);

    // 1: single word, CLKDIV=1, MSB first
    sel = 0;
    push_word(8'b10100101, 8);
    in_data = 8'hA5; in_valid = 1'b1;
    check("t1_ready_idle", rdy[0], 1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check("t1_busy",  bsy[0], 1);
      check("t1_stb",   stb[0], 1);
      check("t1_frame", frm[0], k == 1);
      check("t1_ready", rdy[0], k == 8);
      check("t1_done",  dn[0],  0);
      tick();
    end
    check("t1_end_sdo",   sdo[0], 0);
    check("t1_end_busy",  bsy[0], 0);
    check("t1_end_done",  dn[0],  1);
    check("t1_end_ready", rdy[0], 1);
    tick();
    check("t1_done_clear", dn[0], 0);
    idle(30);

    // 2: CLKDIV=3, each bit held 3 clocks
    sel = 1;
    pat = 8'b10100101;
    push_word(pat, 8);
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      if (k <= 24) check("t2_sdo", sdo[1], pat[7 - (k - 1) / 3]);
      check("t2_stb",   stb[1], (k <= 22) && (k % 3 == 1));
      check("t2_frame", frm[1], k <= 3);
      check("t2_busy",  bsy[1], k <= 24);
      check("t2_done",  dn[1],  k == 25);
      check("t2_ready", rdy[1], k >= 24);
      tick();
    end
    idle(30);

    // 3: back-to-back words with in_valid held high
    sel = 0;
    push_word(8'b10100101, 8);
    push_word(8'b00111100, 8);
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_data = 8'h3C;
    for (int k = 1; k <= 16; k++) begin
      check("t3_busy",  bsy[0], 1);
      check("t3_frame", frm[0], (k == 1) || (k == 9));
      check("t3_done",  dn[0],  k == 9);
      check("t3_ready", rdy[0], (k == 8) || (k == 16));
      tick();
      if (k == 8) in_valid = 1'b0;
    end
    check("t3_end_done", dn[0],  1);
    check("t3_end_busy", bsy[0], 0);
    idle(30);

    // 4: LSB first, idle level high
    sel = 2;
    pat = 8'b10000000;
    check("t4_sdo_before", sdo[2], 1);
    push_word(pat, 8);
    in_data = 8'h01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check("t4_sdo", sdo[2], pat[8 - k]);
      tick();
    end
    check("t4_sdo_after", sdo[2], 1);
    check("t4_done",      dn[2],  1);
    check("t4_busy",      bsy[2], 0);
    tick();
    check("t4_sdo_after2", sdo[2], 1);
    idle(30);

    // 5: in_valid mid-word ignored, re-presented on the last clock accepted
    sel = 0;
    push_word(8'b11000011, 8);
    push_word(8'b11111111, 8);
    in_data = 8'hC3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) begin in_data = 8'hFF; in_valid = 1'b1; end
      if (k == 5) begin in_data = 8'h00; in_valid = 1'b0; end
      if (k == 8) begin in_data = 8'hFF; in_valid = 1'b1; end
      check("t5_ready", rdy[0], k == 8);
      check("t5_frame", frm[0], k == 1);
      tick();
    end
    in_valid = 1'b0;
    check("t5_frame2", frm[0], 1);
    check("t5_done1",  dn[0],  1);
    check("t5_busy",   bsy[0], 1);
    idle(8);
    check("t5_done2",  dn[0],  1);
    check("t5_idle",   bsy[0], 0);
    idle(30);

    // 6: asynchronous reset mid-word
    sel = 0;
    push_word(8'b10100101, 4);
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    idle(4);
    #1 rst = 1'b1;
    #1;
    check("t6_sdo",   sdo[0], 0);
    check("t6_stb",   stb[0], 0);
    check("t6_frame", frm[0], 0);
    check("t6_busy",  bsy[0], 0);
    check("t6_done",  dn[0],  0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t6_no_done", dn[0],  0);
      check("t6_ready",   rdy[0], 1);
      tick();
    end
    push_word(8'b00111100, 8);
    in_data = 8'h3C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    idle(8);
    check("t6_new_done", dn[0],  1);
    check("t6_new_busy", bsy[0], 0);

    idle(5);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/piso_shift.md
Name: piso_shift

Overview:
- Parallel-in serial-out shifter: the transmit-side counterpart of the serial delay/shift pipes in the dsp tree.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit at a time on sdo.
- Each bit is held for CLKDIV clocks, with bit-strobe, frame and done markers for downstream serial sinks (DAC/I2S-style links, test pattern drivers).
- Back-to-back words stream with no idle gap.

Parameters:
- WIDTH, 16, word length in bits (>=2).
- CLKDIV, 1, clocks per serial bit (>=1).
- MSB_FIRST, 1, 1: bit WIDTH-1 is sent first; 0: bit 0 is sent first.
- IDLE, 0, level driven on sdo when no word is being shifted.

Ports:
- ck  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_data  input  WIDTH  word to serialise, sampled on accept.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- sdo  output  1  serial data out (registered).
- bit_stb  output  1  high on the first clock of every bit period (registered).
- frame  output  1  high for the whole first bit period of each word (registered).
- busy  output  1  high while a word is being shifted (registered).
- done  output  1  one-clock pulse on the first clock after a word's last bit period (registered).

Behaviour:
- Reset is asynchronous and active-high. The clock is named ck and the reset rst.
- Reset values, applied asynchronously while rst=1:
  - state=IDLE; shift register, bit counter and divider counter = 0.
  - sdo=IDLE, bit_stb=0, frame=0, busy=0, done=0.
- States:
  - IDLE: in_ready=1. On in_valid=1 at a rising edge, load in_data into the shift register, set bit count=0 and div count=0, go to SHIFT.
  - SHIFT: in_ready=0, except on the last clock of the last bit (bit count=WIDTH-1 and div count=CLKDIV-1), where in_ready=1.
- Latency: the word is accepted at edge N. From edge N to edge N+1: sdo = first bit, bit_stb=1, frame=1, busy=1.
- Bit timing:
  - Each bit is held for exactly CLKDIV clocks.
  - bit_stb is high only on the first clock of each bit.
  - With CLKDIV=1, bit_stb is high for every bit.
  - frame is high for the CLKDIV clocks of bit 0 only.
- Bit order:
  - MSB_FIRST=1: in_data[WIDTH-1] first, then in_data[WIDTH-2], down to in_data[0].
  - MSB_FIRST=0: the reverse order.
- A word occupies exactly WIDTH*CLKDIV clocks.
- End of word, no new word (in_valid=0 on the last clock): return to IDLE. On the next clock sdo=IDLE, busy=0, done=1 for one clock.
- End of word, back-to-back (in_valid=1 on the last clock):
  - Load the new word and stay in SHIFT. There is no gap: the next clock carries bit 0 of the new word with frame=1 and bit_stb=1.
  - busy stays 1, and done=1 on that same clock.
- in_valid while busy (other than on the last clock) is ignored; the word is not consumed and in_data changes have no effect.
- in_ready is combinational from state and counters only. It never depends combinationally on in_valid.
- Reset mid-word aborts immediately. The partial word is discarded and done is not pulsed.
- Counters are sized ceil(log2) of WIDTH and CLKDIV, with a minimum of 1 bit.

Test Plan:
1. WIDTH=8, CLKDIV=1, MSB_FIRST=1, in 0xA5 accepted at edge 0 -> sdo over clocks 1..8 = 1,0,1,0,0,1,0,1; frame=1 only in clock 1; bit_stb=1 in clocks 1..8; busy=1 in clocks 1..8; clock 9: sdo=0, busy=0, done=1; in_ready=0 in clocks 1..7 and 1 in clock 8.
2. WIDTH=8, CLKDIV=3, in 0xA5 -> each bit held 3 clocks (24 clocks total); bit_stb high in clocks 1,4,7,...,22; frame high in clocks 1..3; done in clock 25.
3. Back-to-back: WIDTH=8, CLKDIV=1, 0xA5 then 0x3C with in_valid held high -> 16 contiguous bits 10100101 00111100; frame in clocks 1 and 9; done=1 in clock 9 and again in clock 17; busy continuous over clocks 1..16.
4. MSB_FIRST=0, IDLE=1, in 0x01 -> sdo over clocks 1..8 = 1,0,0,0,0,0,0,0; sdo=1 before and after the word.
5. Data on in_data/in_valid changed mid-word (in_valid=1 in clock 4, not the last clock) -> ignored, the original word completes unchanged; 0xFF presented again in clock 8 is accepted.
6. rst asserted asynchronously in clock 5 of a word -> all outputs return to reset values immediately with no done pulse; after release, in_ready=1 and a new word shifts correctly.
